// File: rtl/pacman_wall_sense_pkg.sv
// Shared pacman constants: VGA raster timing, sprite size, wall-sense types.
// Imported by pacman_movement and the wall-sense block.
package pacman_wall_sense_pkg;

  localparam int PAC_PIXEL_SIZE = 28;
  localparam int VGA_H_LAST     = 799;
  localparam int VGA_V_LAST     = 524;
  localparam int VGA_H_MAX      = 640;
  localparam int VGA_V_MAX      = 480;

  localparam int CNT_W = 6;

  typedef enum logic [1:0] {
    WAIT_FRAME,
    SCAN,
    LATCH
  } state_t;

  // One spare bit over 11-bit signed so sX+H+1 never wraps
  typedef logic signed [11:0] coord_t;

  typedef struct packed {
    logic left;
    logic up;
    logic right;
    logic down;
  } edge_t;

  function automatic coord_t ext(input logic [9:0] v);
    return coord_t'({2'b00, v});
  endfunction

endpackage

// File: rtl/pacman_wall_sense_if.sv
// Raster/position bus into the wall sensor and can-go flags back out.
// master drives the raster side, slave is the wall sensor.
interface pacman_wall_sense_if;

  logic [9:0] hCount;
  logic [9:0] vCount;
  logic       wallFill;
  logic [9:0] pacX;
  logic [9:0] pacY;
  logic       cgLeft;
  logic       cgUp;
  logic       cgRight;
  logic       cgDown;
  logic       senseValid;

  modport master (
    output hCount, vCount, wallFill,
    output pacX, pacY,
    input  cgLeft, cgUp, cgRight, cgDown,
    input  senseValid
  );

  modport slave (
    input  hCount, vCount, wallFill,
    input  pacX, pacY,
    output cgLeft, cgUp, cgRight, cgDown,
    output senseValid
  );

endinterface

// File: rtl/pacman_wall_sense_edge_counter.sv
// Saturating wall-hit counter for one sprite edge.
// Synchronous clear wins over a hit in the same cycle.
module pacman_edge_counter
  import pacman_wall_sense_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             i_clr,
  input  logic             i_hit,
  output logic [CNT_W-1:0] o_count
);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_hit && (r_count != '1)) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/pacman_wall_sense.sv
// Frame-based wall probe around pacman: counts wall pixels on each sprite
// edge during a frame and latches can-go flags at frame end.
module pacman_wall_sense
  import pacman_wall_sense_pkg::*;
#(
  parameter int PIXEL_SIZE = PAC_PIXEL_SIZE,
  parameter int H_LAST     = VGA_H_LAST,
  parameter int V_LAST     = VGA_V_LAST,
  parameter int H_MAX      = VGA_H_MAX,
  parameter int V_MAX      = VGA_V_MAX,
  parameter int unsigned BLOCK_THRESH = 0
) (
  input  logic         clk,
  input  logic         reset,
  pacman_wall_sense_if.slave sense
);

  localparam int     H     = PIXEL_SIZE / 2;
  localparam coord_t C_H   = coord_t'(H);
  localparam coord_t C_ONE = coord_t'(1);
  localparam coord_t C_HM  = coord_t'(H_MAX);
  localparam coord_t C_VM  = coord_t'(V_MAX);

  state_t     r_state;
  state_t     w_next;
  logic [9:0] r_sX;
  logic [9:0] r_sY;
  edge_t      r_cg;
  logic       r_valid;

  logic       w_fstart;
  logic       w_fend;
  logic       w_vis;
  logic       w_cnt_en;
  logic       w_load;
  coord_t     w_h, w_v;
  coord_t     w_x, w_y;
  coord_t     w_xl, w_xr;
  coord_t     w_yt, w_yb;
  logic       w_rows;
  logic       w_cols;
  edge_t      w_match;
  edge_t      w_hit;
  edge_t      w_force;
  edge_t      w_allow;

  logic [CNT_W-1:0] w_cnt_l;
  logic [CNT_W-1:0] w_cnt_u;
  logic [CNT_W-1:0] w_cnt_r;
  logic [CNT_W-1:0] w_cnt_d;

  assign w_fstart = (sense.hCount == 10'd0)
                 && (sense.vCount == 10'd0);
  assign w_fend   = (sense.hCount == 10'(H_LAST))
                 && (sense.vCount == 10'(V_LAST));
  assign w_vis    = (sense.hCount < 10'(H_MAX))
                 && (sense.vCount < 10'(V_MAX));

  assign w_h  = ext(sense.hCount);
  assign w_v  = ext(sense.vCount);
  assign w_x  = ext(r_sX);
  assign w_y  = ext(r_sY);
  assign w_xl = w_x - C_H;
  assign w_xr = w_x + C_H;
  assign w_yt = w_y - C_H;
  assign w_yb = w_y + C_H;

  // Spans exclude the sprite corners, so no pixel hits two edges
  assign w_rows = (w_v >= w_yt + C_ONE) && (w_v <= w_yb);
  assign w_cols = (w_h >= w_xl + C_ONE) && (w_h <= w_xr);

  assign w_match.left  = (w_h == w_xl) && w_rows;
  assign w_match.up    = (w_v == w_yt) && w_cols;
  assign w_match.right = (w_h == w_xr + C_ONE) && w_rows;
  assign w_match.down  = (w_v == w_yb + C_ONE) && w_cols;

  assign w_cnt_en = (r_state == SCAN)
                 && sense.wallFill && w_vis;
  assign w_hit    = w_match & {4{w_cnt_en}};

  assign w_force.left  = w_x < C_H + C_ONE;
  assign w_force.up    = w_y < C_H + C_ONE;
  assign w_force.right = w_xr + C_ONE >= C_HM;
  assign w_force.down  = w_yb + C_ONE >= C_VM;

  assign w_allow.left  = (32'(w_cnt_l) <= BLOCK_THRESH)
                      && !w_force.left;
  assign w_allow.up    = (32'(w_cnt_u) <= BLOCK_THRESH)
                      && !w_force.up;
  assign w_allow.right = (32'(w_cnt_r) <= BLOCK_THRESH)
                      && !w_force.right;
  assign w_allow.down  = (32'(w_cnt_d) <= BLOCK_THRESH)
                      && !w_force.down;

  assign w_load = (r_state == SCAN) && w_fend;

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      WAIT_FRAME: if (w_fstart) w_next = SCAN;
      SCAN:       if (w_fend)   w_next = LATCH;
      LATCH:      w_next = w_fstart ? SCAN : WAIT_FRAME;
      default:    w_next = WAIT_FRAME;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= WAIT_FRAME;
    end else begin
      r_state <= w_next;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sX <= '0;
      r_sY <= '0;
    end else if (w_fstart) begin
      r_sX <= sense.pacX;
      r_sY <= sense.pacY;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cg    <= '0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= w_load;
      if (w_load) r_cg <= w_allow;
    end
  end

  pacman_edge_counter u_cnt_l (
    .clk(clk), .reset(reset),
    .i_clr(w_fstart), .i_hit(w_hit.left),
    .o_count(w_cnt_l)
  );

  pacman_edge_counter u_cnt_u (
    .clk(clk), .reset(reset),
    .i_clr(w_fstart), .i_hit(w_hit.up),
    .o_count(w_cnt_u)
  );

  pacman_edge_counter u_cnt_r (
    .clk(clk), .reset(reset),
    .i_clr(w_fstart), .i_hit(w_hit.right),
    .o_count(w_cnt_r)
  );

  pacman_edge_counter u_cnt_d (
    .clk(clk), .reset(reset),
    .i_clr(w_fstart), .i_hit(w_hit.down),
    .o_count(w_cnt_d)
  );

  assign sense.cgLeft     = r_cg.left;
  assign sense.cgUp       = r_cg.up;
  assign sense.cgRight    = r_cg.right;
  assign sense.cgDown     = r_cg.down;
  assign sense.senseValid = r_valid;

endmodule

// File: tb/tb_pacman_wall_sense.sv
// Directed bench for pacman_wall_sense: a sparse raster covers the probe
// window of each frame; three instances differ in threshold and sprite size.
module tb_pacman_wall_sense;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [9:0] hc = '0;
  logic [9:0] vc = '0;
  logic [9:0] px = '0;
  logic [9:0] py = '0;
  logic       wf = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;

  int wcol = -1;
  int wc0 = 0;
  int wc1 = 0;
  int wrow = -1;
  int wr0 = 0;
  int wr1 = 0;
  bit wall_all = 1'b0;
  bit corners = 1'b0;

  always #5 clk = ~clk;

  pacman_wall_sense_if b0 ();
  pacman_wall_sense_if b27 ();
  pacman_wall_sense_if bbg ();

  assign b0.hCount   = hc;
  assign b0.vCount   = vc;
  assign b0.wallFill = wf;
  assign b0.pacX     = px;
  assign b0.pacY     = py;
  assign b27.hCount   = hc;
  assign b27.vCount   = vc;
  assign b27.wallFill = wf;
  assign b27.pacX     = px;
  assign b27.pacY     = py;
  assign bbg.hCount   = hc;
  assign bbg.vCount   = vc;
  assign bbg.wallFill = wf;
  assign bbg.pacX     = px;
  assign bbg.pacY     = py;

  pacman_wall_sense u0 (
    .clk(clk), .reset(reset), .sense(b0)
  );

  pacman_wall_sense #(.BLOCK_THRESH(27)) u27 (
    .clk(clk), .reset(reset), .sense(b27)
  );

  pacman_wall_sense #(
    .PIXEL_SIZE(140), .BLOCK_THRESH(62)
  ) ubg (
    .clk(clk), .reset(reset), .sense(bbg)
  );

  wire [4:0] o0 = {b0.senseValid, b0.cgLeft,
                   b0.cgUp, b0.cgRight, b0.cgDown};
  wire [4:0] o27 = {b27.senseValid, b27.cgLeft,
                    b27.cgUp, b27.cgRight, b27.cgDown};
  wire [4:0] obg = {bbg.senseValid, bbg.cgLeft,
                    bbg.cgUp, bbg.cgRight, bbg.cgDown};

  function automatic logic wall_at(int h, int v);
    logic c;
    c = (h == 286 || h == 315) && (v == 286 || v == 315);
    return wall_all
        || (h == wcol && v >= wc0 && v <= wc1)
        || (v == wrow && h >= wr0 && h <= wr1)
        || (corners && c);
  endfunction

  task automatic chk(string tag, logic [4:0] obs,
                     logic [4:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %b expected %b",
             tag, obs, exp);
    end
  endtask

  task automatic drive(int h, int v);
    hc = 10'(h);
    vc = 10'(v);
    wf = wall_at(h, v);
    @(negedge clk);
  endtask

  task automatic clear_walls();
    wcol = -1;
    wrow = -1;
    wall_all = 1'b0;
    corners = 1'b0;
  endtask

  task automatic frame(int cx, int cy, int hw, int npx);
    drive(0, 0);
    if (npx >= 0) begin
      px = 10'(npx);
      drive(0, 200);
    end
    for (int v = cy - hw - 2; v <= cy + hw + 2; v++) begin
      for (int h = cx - hw - 2; h <= cx + hw + 3; h++) begin
        if (v >= 0 && h >= 0 && v <= 524 && h <= 799
            && !(h == 0 && v == 0))
          drive(h, v);
      end
    end
    drive(799, 524);
  endtask

  task automatic pos_frame(int x, int y, string tag,
                           logic [4:0] exp);
    px = 10'(x);
    py = 10'(y);
    frame(x, y, 14, -1);
    chk(tag, o0, exp);
  endtask

  initial begin
    @(negedge clk);
    @(negedge clk);
    chk("reset_u0", o0, 5'b00000);
    chk("reset_u27", o27, 5'b00000);
    chk("reset_big", obg, 5'b00000);
    reset = 1'b0;
    px = 10'd300;
    py = 10'd300;

    drive(100, 100);
    drive(799, 524);
    chk("wait_no_latch", o0, 5'b00000);

    frame(300, 300, 14, -1);
    chk("empty_u0", o0, 5'b11111);
    chk("empty_u27", o27, 5'b11111);
    drive(1, 0);
    chk("pulse_end_hold", o0, 5'b01111);

    frame(300, 300, 14, -1);
    chk("empty_again", o0, 5'b11111);

    wcol = 286; wc0 = 0; wc1 = 479;
    frame(300, 300, 14, -1);
    chk("wall_left_u0", o0, 5'b10111);
    chk("wall_left_u27", o27, 5'b10111);

    wcol = 286; wc0 = 287; wc1 = 313;
    frame(300, 300, 14, -1);
    chk("left27_u0", o0, 5'b10111);
    chk("left27_u27", o27, 5'b11111);

    wcol = 315; wc0 = 314; wc1 = 314;
    frame(300, 300, 14, -1);
    chk("right_px_u0", o0, 5'b11101);
    chk("right_px_u27", o27, 5'b11111);

    clear_walls();
    corners = 1'b1;
    frame(300, 300, 14, -1);
    chk("corners_u0", o0, 5'b11111);

    clear_walls();
    wrow = 286; wr0 = 287; wr1 = 314;
    frame(300, 300, 14, -1);
    chk("up_row_u0", o0, 5'b11011);
    chk("up_row_u27", o27, 5'b11011);

    wrow = 315; wr0 = 287; wr1 = 287;
    frame(300, 300, 14, -1);
    chk("down_px_u0", o0, 5'b11110);
    chk("down_px_u27", o27, 5'b11111);

    clear_walls();
    pos_frame(10, 300, "force_l_10", 5'b10111);
    pos_frame(300, 470, "force_d_470", 5'b11110);
    pos_frame(14, 15, "force_l_14", 5'b10111);
    pos_frame(15, 14, "force_u_14", 5'b11011);
    pos_frame(625, 300, "force_r_625", 5'b11101);
    pos_frame(624, 300, "free_r_624", 5'b11111);
    pos_frame(300, 465, "force_d_465", 5'b11110);
    pos_frame(300, 464, "free_d_464", 5'b11111);

    px = 10'd300;
    py = 10'd300;
    wcol = 286; wc0 = 0; wc1 = 479;
    frame(300, 300, 14, 320);
    chk("midchg_old", o0, 5'b10111);
    wcol = 306;
    frame(320, 300, 14, -1);
    chk("midchg_new", o0, 5'b10111);

    clear_walls();
    px = 10'd300;
    drive(0, 0);
    drive(0, 100);
    drive(0, 250);
    reset = 1'b1;
    #1;
    chk("reset_async", o0, 5'b00000);
    @(negedge clk);
    reset = 1'b0;
    drive(300, 260);
    drive(799, 524);
    chk("partial_u0", o0, 5'b00000);
    chk("partial_u27", o27, 5'b00000);
    frame(300, 300, 14, -1);
    chk("after_rst_u0", o0, 5'b11111);
    chk("after_rst_big", obg, 5'b11111);

    wall_all = 1'b1;
    frame(300, 300, 70, -1);
    chk("full_u0", o0, 5'b10000);
    chk("full_u27", o27, 5'b10000);
    chk("full_sat_big", obg, 5'b10000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
